// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared defaults and encodings for the RAM-backed FIFO controller.
// The write FSM encoding is fixed so that waveform viewers and the parent agree on it.
package ram_fifo_ctrl_pkg;

    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 5;
    localparam int DEPTH_DEF = 2 ** AW_DEF;
    localparam int CW_DEF    = AW_DEF + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_t;

endpackage

// File: rtl/ram_fifo_ptr.sv
// AW-bit RAM pointer with increment enable; wraps naturally at 2**AW.
module ram_fifo_ptr
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a dual-address RAM: registered write port,
// combinational-read RAM sampled into pop_data, with commit-delayed occupancy.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          pop_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    output logic          ram_w,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata
);

    wr_state_t     state;
    logic          wr_pend;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;
    logic          commit;

    // Full counts the entry still being written so a back-to-back push can't overrun it.
    assign empty   = (count == '0);
    assign full    = ((count + {{AW{1'b0}}, wr_pend}) == (AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign commit  = wr_pend;

    assign ram_raddr = rd_ptr;

    ram_fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_ok),
        .ptr (wr_ptr)
    );

    ram_fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_ok),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_pend   <= 1'b0;
            count     <= '0;
            ram_w     <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count + {{AW{1'b0}}, commit} - {{AW{1'b0}}, pop_ok};
            wr_pend   <= push_ok;
            overflow  <= push && full;
            underflow <= pop && empty;
            pop_valid <= pop_ok;
            if (pop_ok) begin
                pop_data <= ram_rdata;
            end

            case (state)
                ST_IDLE: begin
                    if (push_ok) begin
                        ram_waddr <= wr_ptr;
                        ram_wdata <= push_data;
                        ram_w     <= 1'b1;
                        state     <= ST_WRITE;
                    end else begin
                        ram_w <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    // Previous entry commits this edge; a new push keeps the port busy.
                    if (push_ok) begin
                        ram_waddr <= wr_ptr;
                        ram_wdata <= push_data;
                        ram_w     <= 1'b1;
                        state     <= ST_WRITE;
                    end else begin
                        ram_w <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    ram_w <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 32x8 RAM attached.
// Driver predicts acceptance and queues expected read data; a monitor checks pop_data.
module tb_ram_fifo_ctrl;
    import ram_fifo_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic [7:0]       push_data = '0;
    logic             pop = 1'b0;
    logic [7:0]       pop_data;
    logic             pop_valid;
    logic             full;
    logic             empty;
    logic [CW_DEF-1:0] count;
    logic             overflow;
    logic             underflow;
    logic             ram_w;
    logic [4:0]       ram_waddr;
    logic [7:0]       ram_wdata;
    logic [4:0]       ram_raddr;
    logic [7:0]       ram_rdata;

    logic [7:0] mem [32];

    int checks = 0;
    int errors = 0;

    int       mcount = 0;
    int       mpend = 0;
    int       mwptr = 0;
    int       exp_waddr = 0;
    int       exp_wdata = 0;
    int       fifo_q[$];
    int       exp_q[$];

    always #5 clk = ~clk;

    ram_fifo_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .ram_w     (ram_w),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    assign ram_rdata = mem[ram_raddr];

    always @(posedge clk) begin
        if (ram_w) mem[ram_waddr] <= ram_wdata;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pop_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && pop_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_data: unexpected pop_valid with data %0d at %0t", pop_data, $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(pop_data) != e) begin
                    errors++;
                    $display("FAIL pop_data: got %0d expected %0d at %0t", pop_data, e, $time);
                end
            end
        end
    end

    task automatic step(input logic p, input logic [7:0] d, input logic q);
        bit mfull, mempty, ap, aq;
        mfull  = (mcount + mpend == 32);
        mempty = (mcount == 0);
        ap = p && !mfull;
        aq = q && !mempty;
        push = p;
        push_data = d;
        pop = q;
        @(posedge clk);
        mcount = mcount + mpend - int'(aq);
        mpend  = int'(ap);
        if (ap) begin
            fifo_q.push_back(int'(d));
            exp_waddr = mwptr;
            exp_wdata = int'(d);
            mwptr = (mwptr + 1) % 32;
        end
        if (aq) exp_q.push_back(fifo_q.pop_front());
        #1;
        push = 1'b0;
        pop = 1'b0;
        chk("count", int'(count), mcount);
        chk("full", int'(full), int'(mcount + mpend == 32));
        chk("empty", int'(empty), int'(mcount == 0));
        chk("overflow", int'(overflow), int'(p && mfull));
        chk("underflow", int'(underflow), int'(q && mempty));
        chk("ram_w", int'(ram_w), int'(ap));
        chk("pop_valid", int'(pop_valid), int'(aq));
        chk("ram_waddr", int'(ram_waddr), exp_waddr);
        chk("ram_wdata", int'(ram_wdata), exp_wdata);
    endtask

    task automatic model_reset();
        mcount = 0; mpend = 0; mwptr = 0; exp_waddr = 0; exp_wdata = 0;
        fifo_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        #12;
        chk("reset_count", int'(count), 0);
        chk("reset_empty", int'(empty), 1);
        chk("reset_full", int'(full), 0);
        chk("reset_ram_w", int'(ram_w), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Pop on empty straight after reset.
        step(0, 8'd0, 1);
        chk("t3_underflow", int'(underflow), 1);
        chk("t3_raddr", int'(ram_raddr), 0);
        step(0, 8'd0, 0);

        // Three pushes, then three pops.
        step(1, 8'd10, 0);
        step(1, 8'd20, 0);
        step(1, 8'd30, 0);
        step(0, 8'd0, 0);
        chk("t1_count", int'(count), 3);
        for (int i = 0; i < 3; i++) step(0, 8'd0, 1);
        step(0, 8'd0, 0);
        chk("t1_empty", int'(empty), 1);
        chk("t1_count0", int'(count), 0);

        // Fill to full, overflow, drain.
        for (int i = 0; i < 32; i++) step(1, 8'(i + 1), 0);
        step(0, 8'd0, 0);
        chk("t2_full", int'(full), 1);
        chk("t2_count", int'(count), 32);
        step(1, 8'd99, 0);
        chk("t2_overflow", int'(overflow), 1);
        chk("t2_no_write", int'(ram_w), 0);
        for (int i = 0; i < 32; i++) step(0, 8'd0, 1);
        step(0, 8'd0, 0);
        chk("t2_empty", int'(empty), 1);

        // Interleaved push/pop across the pointer wrap.
        for (int i = 0; i < 40; i++) step(1, 8'(i * 3), 1);
        for (int i = 0; i < 64 && fifo_q.size() > 0; i++) step(0, 8'd0, 1);
        step(0, 8'd0, 0);
        chk("t4_empty", int'(empty), 1);

        // Steady state at five entries with simultaneous push and pop.
        for (int i = 0; i < 5; i++) step(1, 8'(200 + i), 0);
        step(0, 8'd0, 0);
        chk("t5_count_before", int'(count), 5);
        for (int i = 0; i < 10; i++) step(1, 8'(100 + i), 1);
        step(0, 8'd0, 0);
        chk("t5_count_after", int'(count), 5);
        for (int i = 0; i < 5; i++) step(0, 8'd0, 1);
        step(0, 8'd0, 0);

        // Reset in the middle of a write burst.
        step(1, 8'd7, 0);
        step(1, 8'd8, 0);
        chk("t6_ram_w_pre", int'(ram_w), 1);
        rst = 1'b1;
        #1;
        chk("t6_ram_w", int'(ram_w), 0);
        chk("t6_count", int'(count), 0);
        chk("t6_empty", int'(empty), 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        step(1, 8'h55, 0);
        chk("t6_waddr", int'(ram_waddr), 0);
        step(0, 8'd0, 1);
        step(0, 8'd0, 1);
        step(0, 8'd0, 0);
        step(0, 8'd0, 0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected outputs never seen", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
